// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 8-bit pipeline front end: FSM state encoding
// of the IF/ID hazard controller and the PC/instruction widths used by the
// IF_ID and ID_EX pipeline registers.
package pipe_ctrl_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  // Hazard controller states; the encoding is visible on the debug port.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_STALL  = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_IMEM_WAIT = 2'd3
  } pipe_state_e;

  // Larger of two cycle counts, used to size the shared down-counter.
  function automatic int max_cyc(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// Saturating event counter for performance debug. Counts up by one on each
// cycle with inc set, sticks at all-ones, and clears synchronously on clr
// (clr wins, so an event in the clearing cycle is dropped).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Increment that holds at the maximum representable value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_W'(1));
  endfunction

  // Counter register: async clear on reset, sync clear on clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard and sequencing controller for the 8-bit pipeline front end.
// Generates PC write-enable, IF_ID write-enable/flush and ID_EX bubble from
// load-use hazards, taken branches resolved in EX and instruction-memory
// wait states. Outputs are Mealy (state + inputs, zero latency). Two
// saturating counters record stalled cycles and accepted taken branches.
module if_id_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W      = 2,
  parameter int LU_CYC    = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16,
  parameter bit R0_ZERO   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             clr_stats,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One down-counter serves both LU_STALL and FLUSH; it only needs to hold
  // the larger reload value (cycle count minus the cycle spent in RUN).
  localparam int CMAX = max_cyc(LU_CYC, FLUSH_CYC);
  localparam int DC_W = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [DC_W-1:0] LU_LOAD = DC_W'(LU_CYC - 1);
  localparam logic [DC_W-1:0] FL_LOAD = DC_W'(FLUSH_CYC - 1);

  pipe_state_e     state;
  pipe_state_e     state_nxt;
  logic [DC_W-1:0] dcnt;
  logic [DC_W-1:0] dcnt_nxt;
  logic            dcnt_last;
  logic [DC_W-1:0] dcnt_dec;

  logic rd_valid;
  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic run_eval;
  logic flush_inc;
  logic stall_inc;

  // Load-use detection: a load in EX writes a register the ID instruction
  // reads. Register 0 is exempt when it is hardwired to zero.
  assign rd_valid = (ex_rd != '0) || !R0_ZERO;
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard   = ex_mem_read && rd_valid && (rs1_hit || rs2_hit);

  // A hold state ends after the cycle in which the counter reads 1 (or 0,
  // which only happens on a degenerate reload); the decrement floors at 0.
  assign dcnt_last = (dcnt == '0) || (dcnt == DC_W'(1));
  assign dcnt_dec  = (dcnt == '0) ? '0 : (dcnt - DC_W'(1));

  assign state_o = state;

  // Next-state and Mealy output decode; branch > hold > hazard > imem wait.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_nxt    = state;
    dcnt_nxt     = dcnt;
    flush_inc    = 1'b0;
    run_eval     = 1'b0;

    if (branch_taken) begin
      // Redirect: fetch from the target, squash the wrong-path instruction
      // in IF_ID and the one entering EX. Aborts any hold state.
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
      state_nxt    = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
      dcnt_nxt     = FL_LOAD;
    end else begin
      unique case (state)
        ST_LU_STALL: begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_bubble = 1'b1;
          dcnt_nxt     = dcnt_dec;
          if (dcnt_last) begin
            state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          pc_we        = imem_ready;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          dcnt_nxt     = dcnt_dec;
          if (dcnt_last) begin
            state_nxt = ST_RUN;
          end
        end
        ST_IMEM_WAIT: begin
          if (!imem_ready) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
          end else begin
            run_eval = 1'b1;
          end
        end
        default: begin
          run_eval = 1'b1;
        end
      endcase

      if (run_eval) begin
        if (hazard) begin
          // Hold PC and IF_ID, send a bubble down to EX.
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_bubble = 1'b1;
          state_nxt    = (LU_CYC > 1) ? ST_LU_STALL : ST_RUN;
          dcnt_nxt     = LU_LOAD;
        end else if (!imem_ready) begin
          // No valid instruction: hold PC, load a bubble into IF_ID, let
          // the instruction already in ID proceed.
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
          state_nxt   = ST_IMEM_WAIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
    end

    // While reset is asserted the front end is frozen and fed bubbles.
    if (!reset) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b0;
    end
  end

  assign stall_inc = !pc_we;

  // State and down-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (clr_stats),
    .count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .clr   (clr_stats),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl. Two instances share one stimulus stream:
// A (LU_CYC=1, FLUSH_CYC=2, CNT_W=16, R0 hardwired) and
// B (LU_CYC=3, FLUSH_CYC=3, CNT_W=2, R0 ordinary). Each is compared every
// cycle against a reference model that tracks remaining stall/flush cycles
// and a "waiting for memory" flag, plus directed spot checks.
module tb_if_id_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read;
  logic       branch_taken, imem_ready, clr_stats;

  logic        a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_bubble;
  logic [1:0]  a_state_o;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_bubble;
  logic [1:0]  b_state_o;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  if_id_hazard_ctrl #(
    .RA_W(2), .LU_CYC(1), .FLUSH_CYC(2), .CNT_W(16), .R0_ZERO(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .clr_stats(clr_stats),
    .pc_we(a_pc_we), .if_id_we(a_if_id_we), .if_id_flush(a_if_id_flush),
    .id_ex_bubble(a_id_ex_bubble), .state_o(a_state_o),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  if_id_hazard_ctrl #(
    .RA_W(2), .LU_CYC(3), .FLUSH_CYC(3), .CNT_W(2), .R0_ZERO(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .clr_stats(clr_stats),
    .pc_we(b_pc_we), .if_id_we(b_if_id_we), .if_id_flush(b_if_id_flush),
    .id_ex_bubble(b_id_ex_bubble), .state_o(b_state_o),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs gathered per instance.
  logic        o_pc[2], o_we[2], o_fl[2], o_bub[2];
  logic [31:0] o_st[2], o_sc[2], o_fc[2];
  assign o_pc[0] = a_pc_we;    assign o_pc[1] = b_pc_we;
  assign o_we[0] = a_if_id_we; assign o_we[1] = b_if_id_we;
  assign o_fl[0] = a_if_id_flush;  assign o_fl[1] = b_if_id_flush;
  assign o_bub[0] = a_id_ex_bubble; assign o_bub[1] = b_id_ex_bubble;
  assign o_st[0] = {30'b0, a_state_o};   assign o_st[1] = {30'b0, b_state_o};
  assign o_sc[0] = {16'b0, a_stall_cnt}; assign o_sc[1] = {30'b0, b_stall_cnt};
  assign o_fc[0] = {16'b0, a_flush_cnt}; assign o_fc[1] = {30'b0, b_flush_cnt};

  // Reference model configuration and state.
  string  nm[2]    = '{"A", "B"};
  int     p_lu[2]  = '{1, 3};
  int     p_fl[2]  = '{2, 3};
  bit     p_r0[2]  = '{1'b1, 1'b0};
  longint p_max[2] = '{65535, 3};

  int     lu_left[2];
  int     fl_left[2];
  bit     waiting[2];
  longint m_stall[2];
  longint m_flush[2];

  bit     e_pc[2], e_we[2], e_fl[2], e_bub[2];
  int     e_st[2];
  longint e_sc[2], e_fc[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hazard(input int d);
    bit match;
    match = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
    return ex_mem_read && (ex_rd != 2'd0 || !p_r0[d]) && match;
  endfunction

  task automatic set_out(input int d, input bit pc, input bit we, input bit fl, input bit bub);
    e_pc[d] = pc; e_we[d] = we; e_fl[d] = fl; e_bub[d] = bub;
  endtask

  // Expected outputs for this cycle, then advance the model past the edge.
  task automatic model_step(input int d);
    bit br;
    br = 1'b0;
    if (!reset) begin
      lu_left[d] = 0; fl_left[d] = 0; waiting[d] = 1'b0;
      m_stall[d] = 0; m_flush[d] = 0;
      set_out(d, 1'b0, 1'b0, 1'b1, 1'b1);
      e_st[d] = 0; e_sc[d] = 0; e_fc[d] = 0;
      return;
    end
    e_st[d] = (lu_left[d] > 0) ? 1 : (fl_left[d] > 0) ? 2 : waiting[d] ? 3 : 0;
    e_sc[d] = m_stall[d];
    e_fc[d] = m_flush[d];
    if (branch_taken) begin
      set_out(d, 1'b1, 1'b1, 1'b1, 1'b1);
      lu_left[d] = 0; fl_left[d] = p_fl[d] - 1; waiting[d] = 1'b0; br = 1'b1;
    end else if (lu_left[d] > 0) begin
      set_out(d, 1'b0, 1'b0, 1'b0, 1'b1);
      lu_left[d]--;
    end else if (fl_left[d] > 0) begin
      set_out(d, imem_ready, 1'b1, 1'b1, 1'b1);
      fl_left[d]--;
    end else if (ref_hazard(d) && (!waiting[d] || imem_ready)) begin
      set_out(d, 1'b0, 1'b0, 1'b0, 1'b1);
      lu_left[d] = p_lu[d] - 1; waiting[d] = 1'b0;
    end else if (!imem_ready) begin
      set_out(d, 1'b0, 1'b1, 1'b1, 1'b0);
      waiting[d] = 1'b1;
    end else begin
      set_out(d, 1'b1, 1'b1, 1'b0, 1'b0);
      waiting[d] = 1'b0;
    end
    if (clr_stats) begin
      m_stall[d] = 0; m_flush[d] = 0;
    end else begin
      if (!e_pc[d] && m_stall[d] < p_max[d]) m_stall[d]++;
      if (br && m_flush[d] < p_max[d]) m_flush[d]++;
    end
  endtask

  task automatic compare(input int d);
    check({nm[d], ".pc_we"}, {31'b0, o_pc[d]}, {31'b0, e_pc[d]});
    check({nm[d], ".if_id_we"}, {31'b0, o_we[d]}, {31'b0, e_we[d]});
    check({nm[d], ".if_id_flush"}, {31'b0, o_fl[d]}, {31'b0, e_fl[d]});
    check({nm[d], ".id_ex_bubble"}, {31'b0, o_bub[d]}, {31'b0, e_bub[d]});
    check({nm[d], ".state_o"}, o_st[d], 32'(e_st[d]));
    check({nm[d], ".stall_cnt"}, o_sc[d], 32'(e_sc[d]));
    check({nm[d], ".flush_cnt"}, o_fc[d], 32'(e_fc[d]));
    if (reset) begin
      check({nm[d], ".flush_without_we"}, {31'b0, o_fl[d] & ~o_we[d]}, 32'd0);
    end
  endtask

  // Inputs are set at posedge+1; compare at posedge+3; return at next posedge+1.
  task automatic cycle();
    #2;
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      compare(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_idle();
    id_rs1 = 2'd0; id_rs2 = 2'd0; ex_rd = 2'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; imem_ready = 1'b1; clr_stats = 1'b0;
  endtask

  task automatic set_load_use(input logic [1:0] r);
    ex_mem_read = 1'b1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    @(posedge clk);
    #1;
    // Reset state.
    cycles(2);
    reset = 1'b1;
    cycles(2);

    // Load-use hazard on r2: A stalls one cycle, B three.
    clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
    set_load_use(2'd2);
    #1;
    check("t1_pc_we_a", {31'b0, a_pc_we}, 32'd0);
    check("t1_if_id_we_a", {31'b0, a_if_id_we}, 32'd0);
    check("t1_bubble_a", {31'b0, a_id_ex_bubble}, 32'd1);
    cycle();
    set_idle();
    check("t1_state_a", {30'b0, a_state_o}, 32'd0);
    cycles(4);
    check("t1_stall_cnt_a", {16'b0, a_stall_cnt}, 32'd1);
    check("t1_stall_cnt_b", {30'b0, b_stall_cnt}, 32'd3);

    // Load into r0: no hazard where r0 is hardwired.
    set_load_use(2'd0);
    #1;
    check("t2_pc_we_a", {31'b0, a_pc_we}, 32'd1);
    cycle();
    set_idle();
    cycles(4);
    check("t2_stall_cnt_a", {16'b0, a_stall_cnt}, 32'd1);

    // Single-cycle taken branch.
    clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    #1;
    check("t3_state_flush_a", {30'b0, a_state_o}, 32'd2);
    check("t3_flush_a", {31'b0, a_if_id_flush}, 32'd1);
    cycle();
    check("t3_state_run_a", {30'b0, a_state_o}, 32'd0);
    cycles(2);
    check("t3_flush_cnt_a", {16'b0, a_flush_cnt}, 32'd1);

    // Instruction memory not ready for three cycles.
    clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
    imem_ready = 1'b0;
    cycles(3);
    imem_ready = 1'b1;
    #1;
    check("t4_resume_pc_we_a", {31'b0, a_pc_we}, 32'd1);
    cycle();
    check("t4_stall_cnt_a", {16'b0, a_stall_cnt}, 32'd3);

    // Branch arriving while B sits in LU_STALL.
    clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
    set_load_use(2'd1);
    cycle();
    set_idle();
    branch_taken = 1'b1;
    #1;
    check("t5_state_b", {30'b0, b_state_o}, 32'd1);
    check("t5_pc_we_b", {31'b0, b_pc_we}, 32'd1);
    check("t5_flush_b", {31'b0, b_if_id_flush}, 32'd1);
    cycle();
    branch_taken = 1'b0;
    cycles(3);

    // Reset asserted while A is in FLUSH.
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_state_a", {30'b0, a_state_o}, 32'd0);
    check("t6_pc_we_a", {31'b0, a_pc_we}, 32'd0);
    check("t6_flush_cnt_a", {16'b0, a_flush_cnt}, 32'd0);
    cycles(2);
    reset = 1'b1;
    #1;
    check("t6_release_pc_we_a", {31'b0, a_pc_we}, 32'd1);
    cycles(2);

    // Counter saturation on the 2-bit instance.
    imem_ready = 1'b0;
    cycles(5);
    imem_ready = 1'b1;
    cycle();
    check("sat_stall_cnt_b", {30'b0, b_stall_cnt}, 32'd3);
    check("sat_stall_cnt_a", {16'b0, a_stall_cnt}, 32'd5);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 199) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      ex_rd        = 2'($urandom_range(0, 3));
      id_rs1       = 2'($urandom_range(0, 3));
      id_rs2       = 2'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      imem_ready   = ($urandom_range(0, 3) != 0);
      clr_stats    = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
